// File: rtl/t_toggle_req_gen.sv
`default_nettype none
// ============================================================================
//  Module   : t_toggle_req_gen
//  Purpose  : Synchronise, debounce and one-shot a raw push-button into
//             single-cycle toggle requests, with optional hold-to-repeat.
//  Revision : 1.0  initial release
// ============================================================================
module t_toggle_req_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic en,
    output logic t,
    output logic btn_level
);

    localparam int C_MAX_DR   = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int C_CNT_SPAN = (C_MAX_DR > 2) ? C_MAX_DR : 2;
    localparam int C_CW       = $clog2(C_CNT_SPAN);

    localparam logic [C_CW-1:0] C_ZERO     = '0;
    localparam logic [C_CW-1:0] C_ONE      = C_CW'(1);
    localparam logic [C_CW-1:0] C_DEB_LAST = C_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_CW-1:0] C_REP_LAST = C_CW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    state_t            r_state, w_state_nxt;
    logic [C_CW-1:0]   r_cnt, w_cnt_nxt;
    logic [C_CW-1:0]   r_rcnt, w_rcnt_nxt;
    logic              r_t, w_t_nxt;
    logic              r_level, w_level_nxt;

    // btn_in is asynchronous; only the last stage of the chain is ever observed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= C_ZERO;
            r_rcnt  <= C_ZERO;
            r_t     <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_t     <= w_t_nxt;
            r_level <= w_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rcnt_nxt  = r_rcnt;
        w_t_nxt     = 1'b0;
        w_level_nxt = r_level;

        case (r_state)
            ST_IDLE: begin
                w_level_nxt = 1'b0;
                if (w_s) begin
                    w_state_nxt = ST_DEB_PRESS;
                    w_cnt_nxt   = C_ONE;
                end
            end

            ST_DEB_PRESS: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = C_ZERO;
                end else if (r_cnt == C_DEB_LAST) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = C_ZERO;
                    w_rcnt_nxt  = C_ZERO;
                    w_level_nxt = 1'b1;
                    w_t_nxt     = en;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end

            ST_PRESSED: begin
                w_level_nxt = 1'b1;
                if (!w_s) begin
                    w_state_nxt = ST_DEB_RELEASE;
                    w_cnt_nxt   = C_ONE;
                end else if (REPEAT_CYCLES != 0) begin
                    if (r_rcnt == C_REP_LAST) begin
                        w_t_nxt    = en;
                        w_rcnt_nxt = C_ZERO;
                    end else begin
                        w_rcnt_nxt = r_rcnt + C_ONE;
                    end
                end
            end

            ST_DEB_RELEASE: begin
                // A bounce back to 1 resumes the hold with the repeat phase preserved.
                w_level_nxt = 1'b1;
                if (w_s) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = C_ZERO;
                end else if (r_cnt == C_DEB_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = C_ZERO;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = C_ZERO;
                w_rcnt_nxt  = C_ZERO;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign t         = r_t;
    assign btn_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_t_toggle_req_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_t_toggle_req_gen
//  Purpose  : Directed self-checking bench for t_toggle_req_gen (default and
//             REPEAT_CYCLES=8 instances sharing stimulus).
//  Revision : 1.0  initial release
// ============================================================================
module tb_t_toggle_req_gen;

    logic clk;
    logic reset;
    logic btn_in;
    logic en;
    logic t0, lvl0;
    logic t1, lvl1;
    logic q;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;

    logic hist_t0 [0:127];
    logic hist_l0 [0:127];
    logic hist_t1 [0:127];
    logic hist_l1 [0:127];
    logic hist_q  [0:127];

    t_toggle_req_gen u_dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .en        (en),
        .t         (t0),
        .btn_level (lvl0)
    );

    t_toggle_req_gen #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) u_dut_rep (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .en        (en),
        .t         (t1),
        .btn_level (lvl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream T flip-flop fed by the default instance.
    always @(posedge clk) begin
        if (reset) q <= 1'b0;
        else if (t0) q <= ~q;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (edge_n < 127) edge_n++;
        hist_t0[edge_n] = t0;
        hist_l0[edge_n] = lvl0;
        hist_t1[edge_n] = t1;
        hist_l1[edge_n] = lvl1;
        hist_q[edge_n]  = q;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        btn_in = 1'b0;
        en     = 1'b1;
        run(2);
        reset = 1'b0;
        run(3);
        edge_n = 0;
    endtask

    function automatic logic pick(input int sel, input int i);
        case (sel)
            0:       return hist_t0[i];
            1:       return hist_t1[i];
            2:       return hist_l0[i];
            default: return hist_l1[i];
        endcase
    endfunction

    function automatic int count_hi(input int sel, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (pick(sel, i) === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_hi(input int sel, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (pick(sel, i) === 1'b1) return i;
        return -1;
    endfunction

    function automatic int first_lo(input int sel, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (pick(sel, i) === 1'b0) return i;
        return -1;
    endfunction

    function automatic int adjacent(input int sel, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i < hi; i++) if (pick(sel, i) === 1'b1 && pick(sel, i + 1) === 1'b1) c++;
        return c;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] bounce;
        reset  = 1'b1;
        btn_in = 1'b1;
        en     = 1'b1;

        // 1: reset held with button pressed, then first pulse after edge 6.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_t", {31'd0, t0}, 32'd0);
            check_val("rst_lvl", {31'd0, lvl0}, 32'd0);
            check_val("rst_t_rep", {31'd0, t1}, 32'd0);
        end
        reset  = 1'b0;
        edge_n = 0;
        run(10);
        check_val("rst_first_pulse", first_hi(0, 1, 10), 6);
        check_val("rst_pulse_cnt", count_hi(0, 1, 10), 1);
        check_val("rst_lvl_rise", first_hi(2, 1, 10), 6);

        // 2: clean press then release.
        do_reset();
        btn_in = 1'b1;
        run(20);
        check_val("press_pulse_edge", first_hi(0, 1, 20), 6);
        check_val("press_pulse_cnt", count_hi(0, 1, 20), 1);
        check_val("press_lvl_edge", first_hi(2, 1, 20), 6);
        btn_in = 1'b0;
        run(20);
        check_val("release_no_t", count_hi(0, 21, 40), 0);
        check_val("release_lvl_fall", first_lo(2, 21, 40), 26);

        // 3: bounce 1,0,1,1,0,1 then steady 1.
        do_reset();
        bounce = 6'b101101;
        for (int i = 5; i >= 0; i--) begin
            btn_in = bounce[i];
            tick();
        end
        btn_in = 1'b1;
        run(19);
        check_val("bounce_pulse_edge", first_hi(0, 1, 25), 11);
        check_val("bounce_pulse_cnt", count_hi(0, 1, 25), 1);
        check_val("bounce_lvl_edge", first_hi(2, 1, 25), 11);

        // 4: hold-to-repeat with period 8, none after release.
        do_reset();
        btn_in = 1'b1;
        run(40);
        btn_in = 1'b0;
        run(20);
        check_val("rep_p6", {31'd0, hist_t1[6]}, 32'd1);
        check_val("rep_p14", {31'd0, hist_t1[14]}, 32'd1);
        check_val("rep_p22", {31'd0, hist_t1[22]}, 32'd1);
        check_val("rep_p30", {31'd0, hist_t1[30]}, 32'd1);
        check_val("rep_p38", {31'd0, hist_t1[38]}, 32'd1);
        check_val("rep_cnt_hold", count_hi(1, 1, 40), 5);
        check_val("rep_cnt_release", count_hi(1, 41, 60), 0);
        check_val("rep_adjacent", adjacent(1, 1, 60), 0);
        check_val("norep_cnt", count_hi(0, 1, 60), 1);

        // 4b: single-cycle release glitch mid-hold freezes the repeat phase.
        do_reset();
        btn_in = 1'b1;
        run(9);
        btn_in = 1'b0;
        tick();
        btn_in = 1'b1;
        run(15);
        check_val("glitch_p6", {31'd0, hist_t1[6]}, 32'd1);
        check_val("glitch_p16", {31'd0, hist_t1[16]}, 32'd1);
        check_val("glitch_p24", {31'd0, hist_t1[24]}, 32'd1);
        check_val("glitch_cnt", count_hi(1, 1, 25), 3);
        check_val("glitch_lvl_held", first_lo(3, 6, 25), -1);

        // 5: en low on the first pulse cycle drops only that pulse.
        do_reset();
        btn_in = 1'b1;
        run(5);
        en = 1'b0;
        tick();
        en = 1'b1;
        run(9);
        check_val("en_drop_p6", {31'd0, hist_t1[6]}, 32'd0);
        check_val("en_lvl_p6", {31'd0, hist_l1[6]}, 32'd1);
        check_val("en_next_p14", {31'd0, hist_t1[14]}, 32'd1);
        check_val("en_cnt", count_hi(1, 1, 15), 1);

        // Reset mid-debounce aborts without a pulse.
        do_reset();
        btn_in = 1'b1;
        run(4);
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        btn_in = 1'b0;
        run(10);
        check_val("abort_no_t", count_hi(0, 1, 15), 0);
        check_val("abort_no_lvl", count_hi(2, 1, 15), 0);

        // 6: three presses driving the T flop.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            btn_in = 1'b1;
            run(10);
            btn_in = 1'b0;
            run(10);
        end
        check_val("tff_q6", {31'd0, hist_q[6]}, 32'd0);
        check_val("tff_q7", {31'd0, hist_q[7]}, 32'd1);
        check_val("tff_q26", {31'd0, hist_q[26]}, 32'd1);
        check_val("tff_q27", {31'd0, hist_q[27]}, 32'd0);
        check_val("tff_q46", {31'd0, hist_q[46]}, 32'd0);
        check_val("tff_q47", {31'd0, hist_q[47]}, 32'd1);
        check_val("tff_q_final", {31'd0, hist_q[60]}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
